// File: rtl/tx_frame_pkg.sv
// Shared definitions for the nRF transmit framer: frame states, defaults
// and the running checksum helper.
package tx_frame_pkg;

   localparam int          BYTE_W              = 8;
   localparam logic [7:0]  PREAMBLE_DEFAULT    = 8'hAA;
   localparam int          MAX_PAYLOAD_DEFAULT = 32;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_ADDR     = 3'd2,
      ST_LEN      = 3'd3,
      ST_PAYLOAD  = 3'd4,
      ST_CHK      = 3'd5,
      ST_DONE     = 3'd6
   } state_t;

   function automatic logic [BYTE_W-1:0] chk_accum(
      input logic [BYTE_W-1:0] acc,
      input logic [BYTE_W-1:0] data
   );
      return acc ^ data;
   endfunction

endpackage

// File: rtl/tx_byte_reg.sv
// Output holding register for the framer byte stream; keeps the byte stable
// while downstream stalls and drops valid only on a completed transfer.
module tx_byte_reg
   import tx_frame_pkg::*;
(
   input  logic              i_Clk,
   input  logic              i_Rst_L,
   input  logic              i_Load,
   input  logic [BYTE_W-1:0] i_Load_Byte,
   input  logic              i_Tx_Ready,
   output logic              o_Tx_DV,
   output logic [BYTE_W-1:0] o_Tx_Byte,
   output logic              o_Xfer
);

   assign o_Xfer = o_Tx_DV && i_Tx_Ready;

   // Load wins over transfer so a new byte can follow the previous one back-to-back.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         o_Tx_DV   <= 1'b0;
         o_Tx_Byte <= {BYTE_W{1'b0}};
      end else if (i_Load) begin
         o_Tx_DV   <= 1'b1;
         o_Tx_Byte <= i_Load_Byte;
      end else if (o_Xfer) begin
         o_Tx_DV   <= 1'b0;
         o_Tx_Byte <= o_Tx_Byte;
      end else begin
         o_Tx_DV   <= o_Tx_DV;
         o_Tx_Byte <= o_Tx_Byte;
      end
   end

endmodule

// File: rtl/tx_frame_builder.sv
// nRF transmit framer: preamble, address (MSB first), length, payload and
// XOR checksum streamed over valid/ready toward the radio SPI path.
module tx_frame_builder
   import tx_frame_pkg::*;
#(
   parameter int         ADDR_BYTES  = 3,
   parameter logic [7:0] PREAMBLE    = PREAMBLE_DEFAULT,
   parameter int         MAX_PAYLOAD = MAX_PAYLOAD_DEFAULT
) (
   input  logic                     i_Clk,
   input  logic                     i_Rst_L,
   input  logic                     i_Start,
   input  logic [8*ADDR_BYTES-1:0]  i_Addr,
   input  logic [7:0]               i_Len,
   input  logic                     i_Pay_DV,
   input  logic [7:0]               i_Pay_Byte,
   output logic                     o_Pay_Ready,
   output logic                     o_Tx_DV,
   output logic [7:0]               o_Tx_Byte,
   input  logic                     i_Tx_Ready,
   output logic                     o_Busy,
   output logic                     o_Done
);

   localparam int         AW        = BYTE_W * ADDR_BYTES;
   localparam logic [7:0] MAX_LEN   = 8'(MAX_PAYLOAD);
   localparam logic [2:0] LAST_ADDR = 3'(ADDR_BYTES - 1);

   state_t      state_r;
   logic [AW-1:0] addr_r;
   logic [2:0]  addr_idx_r;
   logic [7:0]  len_r;
   logic [7:0]  remaining_r;
   logic [7:0]  chk_r;
   logic        busy_r;
   logic        done_r;

   logic        load_s;
   logic [7:0]  load_byte_s;
   logic        xfer_s;
   logic        tx_dv_s;
   logic [7:0]  tx_byte_s;
   logic [7:0]  clamp_len_s;
   logic        pay_ready_s;
   logic        pay_take_s;

   // Oversized requests are clamped; the clamped value is both sent and counted.
   always_comb begin
      clamp_len_s = i_Len;
      if (i_Len > MAX_LEN) begin
         clamp_len_s = MAX_LEN;
      end else begin
         clamp_len_s = i_Len;
      end
   end

   // Payload is pulled while the length byte drains so the first payload byte follows without a gap.
   always_comb begin
      pay_ready_s = 1'b0;
      if (((state_r == ST_LEN) || (state_r == ST_PAYLOAD)) && (remaining_r != 8'd0)) begin
         pay_ready_s = !tx_dv_s || i_Tx_Ready;
      end else begin
         pay_ready_s = 1'b0;
      end
   end

   assign pay_take_s = pay_ready_s && i_Pay_DV;

   // Selects what the holding register loads next; checksum folds in the byte leaving this edge.
   always_comb begin
      load_s      = 1'b0;
      load_byte_s = 8'h00;
      case (state_r)
         ST_IDLE: begin
            if (i_Start) begin
               load_s      = 1'b1;
               load_byte_s = PREAMBLE;
            end else begin
               load_s      = 1'b0;
            end
         end
         ST_PREAMBLE: begin
            if (xfer_s) begin
               load_s      = 1'b1;
               load_byte_s = addr_r[AW-1 -: 8];
            end else begin
               load_s      = 1'b0;
            end
         end
         ST_ADDR: begin
            if (xfer_s) begin
               load_s      = 1'b1;
               load_byte_s = (addr_idx_r == LAST_ADDR) ? len_r : addr_r[AW-1 -: 8];
            end else begin
               load_s      = 1'b0;
            end
         end
         ST_LEN, ST_PAYLOAD: begin
            if (pay_take_s) begin
               load_s      = 1'b1;
               load_byte_s = i_Pay_Byte;
            end else if (xfer_s && (remaining_r == 8'd0)) begin
               load_s      = 1'b1;
               load_byte_s = chk_accum(chk_r, tx_byte_s);
            end else begin
               load_s      = 1'b0;
            end
         end
         default: begin
            load_s      = 1'b0;
            load_byte_s = 8'h00;
         end
      endcase
   end

   // Frame sequencer; the address register shifts so its top byte is always the next one out.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_r     <= ST_IDLE;
         addr_r      <= {AW{1'b0}};
         addr_idx_r  <= 3'd0;
         len_r       <= 8'd0;
         remaining_r <= 8'd0;
         chk_r       <= 8'd0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (i_Start) begin
                  addr_r      <= i_Addr;
                  len_r       <= clamp_len_s;
                  remaining_r <= clamp_len_s;
                  chk_r       <= 8'd0;
                  addr_idx_r  <= 3'd0;
                  busy_r      <= 1'b1;
                  state_r     <= ST_PREAMBLE;
               end
            end
            ST_PREAMBLE: begin
               if (xfer_s) begin
                  addr_r  <= addr_r << 4'd8;
                  state_r <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (xfer_s) begin
                  chk_r <= chk_accum(chk_r, tx_byte_s);
                  if (addr_idx_r == LAST_ADDR) begin
                     state_r <= ST_LEN;
                  end else begin
                     addr_idx_r <= addr_idx_r + 3'd1;
                     addr_r     <= addr_r << 4'd8;
                  end
               end
            end
            ST_LEN: begin
               if (xfer_s) begin
                  chk_r <= chk_accum(chk_r, tx_byte_s);
                  if (pay_take_s) begin
                     remaining_r <= remaining_r - 8'd1;
                  end
                  state_r <= (len_r == 8'd0) ? ST_CHK : ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (pay_take_s) begin
                  remaining_r <= remaining_r - 8'd1;
               end
               if (xfer_s) begin
                  chk_r <= chk_accum(chk_r, tx_byte_s);
                  if (remaining_r == 8'd0) begin
                     state_r <= ST_CHK;
                  end
               end
            end
            ST_CHK: begin
               if (xfer_s) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   tx_byte_reg u_byte_reg (
      .i_Clk       (i_Clk),
      .i_Rst_L     (i_Rst_L),
      .i_Load      (load_s),
      .i_Load_Byte (load_byte_s),
      .i_Tx_Ready  (i_Tx_Ready),
      .o_Tx_DV     (tx_dv_s),
      .o_Tx_Byte   (tx_byte_s),
      .o_Xfer      (xfer_s)
   );

   assign o_Tx_DV     = tx_dv_s;
   assign o_Tx_Byte   = tx_byte_s;
   assign o_Pay_Ready = pay_ready_s;
   assign o_Busy      = busy_r;
   assign o_Done      = done_r;

endmodule

// File: tb/tb_tx_frame_builder.sv
// Self-checking bench for tx_frame_builder: directed scenarios plus randomized
// frames compared against a byte-list reference model.
module tb_tx_frame_builder;

   localparam int ADDR_BYTES  = 3;
   localparam int MAX_PAYLOAD = 32;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        start;
   logic [23:0] addr;
   logic [7:0]  len;
   logic        pay_dv;
   logic [7:0]  pay_byte;
   logic        pay_ready;
   logic        tx_dv;
   logic [7:0]  tx_byte;
   logic        tx_ready;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   logic [7:0] pay_src_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   always #5 clk = ~clk;

   tx_frame_builder #(
      .ADDR_BYTES  (ADDR_BYTES),
      .PREAMBLE    (8'hAA),
      .MAX_PAYLOAD (MAX_PAYLOAD)
   ) dut (
      .i_Clk       (clk),
      .i_Rst_L     (rst_l),
      .i_Start     (start),
      .i_Addr      (addr),
      .i_Len       (len),
      .i_Pay_DV    (pay_dv),
      .i_Pay_Byte  (pay_byte),
      .o_Pay_Ready (pay_ready),
      .o_Tx_DV     (tx_dv),
      .o_Tx_Byte   (tx_byte),
      .i_Tx_Ready  (tx_ready),
      .o_Busy      (busy),
      .o_Done      (done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: frame as a plain byte list built from the framing rules.
   function automatic void build_expected(input logic [23:0] a, input logic [7:0] l);
      int         n;
      logic [7:0] c;
      logic [7:0] b;
      n = (int'(l) > MAX_PAYLOAD) ? MAX_PAYLOAD : int'(l);
      exp_q.delete();
      c = 8'h00;
      exp_q.push_back(8'hAA);
      for (int i = ADDR_BYTES - 1; i >= 0; i--) begin
         b = a[8*i +: 8];
         exp_q.push_back(b);
         c = c ^ b;
      end
      exp_q.push_back(8'(n));
      c = c ^ 8'(n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(pay_src_q[i]);
         c = c ^ pay_src_q[i];
      end
      exp_q.push_back(c);
   endfunction

   task automatic fill_payload(input int n);
      pay_src_q.delete();
      for (int i = 0; i < n; i++) pay_src_q.push_back(8'($urandom));
   endtask

   task automatic run_frame(input string tag, input logic [23:0] a, input logic [7:0] l,
                            input int ready_mode, input bit pay_stall, input bit restart,
                            input bit check_b2b);
      int         pulled;
      int         first_x;
      int         last_x;
      int         n_pay;
      bit         seen_pr;
      bit         stall_prev;
      bit         finished;
      logic [7:0] held;
      build_expected(a, l);
      n_pay = exp_q.size() - ADDR_BYTES - 3;
      got_q.delete();
      pulled = 0; first_x = -1; last_x = -1;
      seen_pr = 1'b0; stall_prev = 1'b0; finished = 1'b0; held = 8'h00;
      @(posedge clk); #1;
      start = 1'b1; addr = a; len = l;
      @(posedge clk); #1;
      start = 1'b0; addr = 24'($urandom); len = 8'($urandom);
      check_eq({tag, "_lat_dv"}, 32'(tx_dv), 32'd1);
      check_eq({tag, "_lat_byte"}, 32'(tx_byte), 32'hAA);
      check_eq({tag, "_lat_busy"}, 32'(busy), 32'd1);
      for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
         case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: tx_ready = 1'($urandom_range(0, 1));
         endcase
         pay_dv   = (pay_src_q.size() > 0) && (!pay_stall || ($urandom_range(0, 2) != 0));
         pay_byte = pay_dv ? pay_src_q[0] : 8'($urandom);
         start    = restart && (cyc == 2);
         @(negedge clk);
         if (stall_prev) begin
            check_eq({tag, "_stall_dv"}, 32'(tx_dv), 32'd1);
            check_eq({tag, "_stall_byte"}, 32'(tx_byte), 32'(held));
         end
         stall_prev = tx_dv && !tx_ready;
         held       = tx_byte;
         if (tx_dv && tx_ready) begin
            got_q.push_back(tx_byte);
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
         end
         if (pay_ready) seen_pr = 1'b1;
         if (pay_ready && pay_dv) begin
            void'(pay_src_q.pop_front());
            pulled++;
         end
         if (done) begin
            finished = 1'b1;
            check_eq({tag, "_done_busy"}, 32'(busy), 32'd0);
            check_eq({tag, "_done_dv"}, 32'(tx_dv), 32'd0);
         end else begin
            @(posedge clk); #1;
         end
      end
      start = 1'b0;
      check_eq({tag, "_finished"}, 32'(finished), 32'd1);
      check_eq({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) check_eq($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      end
      check_eq({tag, "_pulled"}, 32'(pulled), 32'(n_pay));
      if (n_pay == 0) check_eq({tag, "_no_pay_ready"}, 32'(seen_pr), 32'd0);
      if (check_b2b) check_eq({tag, "_b2b"}, 32'(last_x - first_x), 32'(exp_q.size() - 1));
      pay_src_q.delete();
   endtask

   task automatic check_idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_eq({tag, "_idle_dv"}, 32'(tx_dv), 32'd0);
         check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
         check_eq({tag, "_idle_done"}, 32'(done), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_dv"}, 32'(tx_dv), 32'd0);
      check_eq({tag, "_byte"}, 32'(tx_byte), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_done"}, 32'(done), 32'd0);
      check_eq({tag, "_pay_ready"}, 32'(pay_ready), 32'd0);
   endtask

   task automatic reset_mid_frame();
      fill_payload(10);
      @(posedge clk); #1;
      start = 1'b1; addr = 24'h123456; len = 8'd10;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tx_ready = 1'b1;
         pay_dv   = 1'b1;
         pay_byte = 8'($urandom);
         @(posedge clk); #1;
      end
      check_eq("rst_mid_pre_dv", 32'(tx_dv), 32'd1);
      check_eq("rst_mid_pre_busy", 32'(busy), 32'd1);
      #2;
      rst_l = 1'b0;
      #1;
      check_reset_values("rst_mid");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_l  = 1'b1;
      pay_dv = 1'b0;
      pay_src_q.delete();
   endtask

   initial begin
      logic [23:0] ra;
      logic [7:0]  rl;
      rst_l = 1'b0; start = 1'b0; addr = 24'h0; len = 8'h0;
      pay_dv = 1'b0; pay_byte = 8'h0; tx_ready = 1'b0;
      #12;
      check_reset_values("reset");
      @(negedge clk);
      rst_l = 1'b1;

      // 1: basic frame
      pay_src_q.delete(); pay_src_q.push_back(8'h11); pay_src_q.push_back(8'h22);
      run_frame("basic", 24'hE7E7E7, 8'd2, 0, 1'b0, 1'b0, 1'b1);
      check_idle("basic", 2);

      // 2: empty payload
      pay_src_q.delete();
      run_frame("empty", 24'hABCDEF, 8'd0, 0, 1'b0, 1'b0, 1'b1);

      // 3: downstream backpressure 1,0,0,1
      pay_src_q.delete(); pay_src_q.push_back(8'h11); pay_src_q.push_back(8'h22);
      run_frame("bp", 24'hE7E7E7, 8'd2, 1, 1'b0, 1'b0, 1'b0);

      // 4: length clamp
      fill_payload(40);
      run_frame("clamp", 24'h5A3C01, 8'd40, 0, 1'b0, 1'b0, 1'b1);

      // 5: start while busy ignored, immediate restart after done
      pay_src_q.delete(); pay_src_q.push_back(8'h11); pay_src_q.push_back(8'h22);
      run_frame("busy_start", 24'hE7E7E7, 8'd2, 0, 1'b0, 1'b1, 1'b1);
      fill_payload(3);
      run_frame("restart", 24'h010203, 8'd3, 0, 1'b0, 1'b0, 1'b1);
      check_idle("restart", 2);

      // 6: reset mid-frame, then a clean frame
      reset_mid_frame();
      pay_src_q.delete(); pay_src_q.push_back(8'h11); pay_src_q.push_back(8'h22);
      run_frame("post_rst", 24'hE7E7E7, 8'd2, 0, 1'b0, 1'b0, 1'b1);

      // randomized frames with random backpressure and upstream stalls
      for (int f = 0; f < 12; f++) begin
         ra = 24'($urandom);
         rl = 8'($urandom_range(0, 40));
         fill_payload(int'(rl));
         run_frame($sformatf("rand%0d", f), ra, rl, int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      check_idle("final", 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
